// File: rtl/frame_capture_ctrl.sv
// Camera frame capture sequencer: windows the pixel stream into a 120x120
// ping-pong frame buffer pair and swaps banks at end of frame under a reader lock.
module frame_capture_ctrl #(
  parameter int WIDTH      = 120,
  parameter int HEIGHT     = 120,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        vref,
  input  logic        href,
  input  logic        pix_valid,
  input  logic [15:0] pixel,
  input  logic        rd_lock,
  output logic        wren,
  output logic [14:0] wraddr,
  output logic [15:0] wrdata,
  output logic        wr_bank,
  output logic        rd_bank,
  output logic        frame_done,
  output logic        busy,
  output logic [7:0]  frame_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_SYNC    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_SWAP    = 3'd4;

  localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
  localparam logic [9:0] HEIGHT_L = 10'(HEIGHT);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  logic [2:0]  state_q, state_d;
  logic        vref_d_q, vref_d_d;
  logic        href_d_q, href_d_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        first_line_q, first_line_d;
  logic        wren_q, wren_d;
  logic [14:0] wraddr_q, wraddr_d;
  logic [15:0] wrdata_q, wrdata_d;
  logic        wr_bank_q, wr_bank_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_count_q, frame_count_d;

  logic        vref_rise, href_rise;
  logic [9:0]  x_eff, y_eff;

  assign vref_rise = vref & ~vref_d_q;
  assign href_rise = href & ~href_d_q;

  always_comb begin
    state_d       = state_q;
    vref_d_d      = vref;
    href_d_d      = href;
    x_d           = x_q;
    y_d           = y_q;
    first_line_d  = first_line_q;
    wren_d        = 1'b0;
    wraddr_d      = wraddr_q;
    wrdata_d      = wrdata_q;
    wr_bank_d     = wr_bank_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    x_eff         = x_q;
    y_eff         = y_q;

    case (state_q)
      S_IDLE: begin
        if (capture) state_d = S_ARM;
      end
      S_ARM: begin
        if (vref_rise) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (!vref) begin
          state_d      = S_CAPTURE;
          x_d          = 10'd0;
          y_d          = 10'd0;
          first_line_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (vref_rise) begin
          state_d = S_SWAP;
        end else begin
          // A line start coincident with a pixel places that pixel at column 0.
          if (href_rise) begin
            x_eff = 10'd0;
            if (first_line_q) first_line_d = 1'b0;
            else              y_eff = sat_inc(y_q);
          end
          x_d = x_eff;
          y_d = y_eff;
          if (pix_valid && href) begin
            if ((x_eff < WIDTH_L) && (y_eff < HEIGHT_L)) begin
              wren_d   = 1'b1;
              wraddr_d = {y_eff[6:0], x_eff[6:0]};
              wrdata_d = pixel;
            end
            x_d = sat_inc(x_eff);
          end
        end
      end
      S_SWAP: begin
        if (!rd_lock) begin
          wr_bank_d     = ~wr_bank_q;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          state_d       = CONTINUOUS ? S_ARM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      vref_d_q      <= 1'b0;
      href_d_q      <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      first_line_q  <= 1'b0;
      wren_q        <= 1'b0;
      wraddr_q      <= 15'd0;
      wrdata_q      <= 16'd0;
      wr_bank_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      vref_d_q      <= vref_d_d;
      href_d_q      <= href_d_d;
      x_q           <= x_d;
      y_q           <= y_d;
      first_line_q  <= first_line_d;
      wren_q        <= wren_d;
      wraddr_q      <= wraddr_d;
      wrdata_q      <= wrdata_d;
      wr_bank_q     <= wr_bank_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign wren        = wren_q;
  assign wraddr      = wraddr_q;
  assign wrdata      = wrdata_q;
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = ~wr_bank_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl: one-shot instance checked write-by-write,
// continuous instance checked on swaps, bank sequence and write counts.
module tb_frame_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cap0 = 1'b0, cap1 = 1'b0;
  logic        vref = 1'b0, href = 1'b0, pix_valid = 1'b0, rd_lock = 1'b0;
  logic [15:0] pixel = 16'd0;

  logic        wren0, wr_bank0, rd_bank0, frame_done0, busy0;
  logic [14:0] wraddr0;
  logic [15:0] wrdata0;
  logic [7:0]  frame_count0;
  logic        wren1, wr_bank1, rd_bank1, frame_done1, busy1;
  logic [14:0] wraddr1;
  logic [15:0] wrdata1;
  logic [7:0]  frame_count1;

  frame_capture_ctrl #(.WIDTH(120), .HEIGHT(120), .CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .capture(cap0), .vref(vref), .href(href),
    .pix_valid(pix_valid), .pixel(pixel), .rd_lock(rd_lock),
    .wren(wren0), .wraddr(wraddr0), .wrdata(wrdata0), .wr_bank(wr_bank0),
    .rd_bank(rd_bank0), .frame_done(frame_done0), .busy(busy0),
    .frame_count(frame_count0)
  );

  frame_capture_ctrl #(.WIDTH(120), .HEIGHT(120), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .capture(cap1), .vref(vref), .href(href),
    .pix_valid(pix_valid), .pixel(pixel), .rd_lock(rd_lock),
    .wren(wren1), .wraddr(wraddr1), .wrdata(wrdata1), .wr_bank(wr_bank1),
    .rd_bank(rd_bank1), .frame_done(frame_done1), .busy(busy1),
    .frame_count(frame_count1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [30:0] exp_q[$];
  int wr_cnt = 0, fd0_cnt = 0, wr1_cnt = 0, fd1_cnt = 0, busy1_drop = 0;
  logic [14:0] first_addr = 15'h7fff, last_addr = 15'h7fff;
  bit seen_3b80 = 1'b0;
  bit mon_busy1 = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every write strobe of the one-shot instance is matched against the queue.
  always @(negedge clk) begin
    if (wren0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty queue", wraddr0, wrdata0);
      end else begin
        logic [30:0] e;
        e = exp_q.pop_front();
        if ({wraddr0, wrdata0} != e) begin
          errors++;
          $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   wraddr0, wrdata0, e[30:16], e[15:0]);
        end
      end
      if (wr_cnt == 0) first_addr = wraddr0;
      last_addr = wraddr0;
      if (wraddr0 == 15'h3B80) seen_3b80 = 1'b1;
      wr_cnt++;
    end
    if (frame_done0) fd0_cnt++;
    if (wren1) wr1_cnt++;
    if (frame_done1) fd1_cnt++;
    if (mon_busy1 && !busy1) busy1_drop++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pix_of(input int y, input int c);
    return 16'((y << 8) + c) ^ 16'hA5C3;
  endfunction

  task automatic vsync();
    vref = 1'b1;
    repeat (4) tick();
    vref = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int ncols, input int y, input bit push, input bit lead);
    href = 1'b1;
    if (lead) tick();
    for (int c = 0; c < ncols; c++) begin
      pixel = pix_of(y, c);
      pix_valid = 1'b1;
      if (push && c < 120 && y < 120) exp_q.push_back({7'(y), 7'(c), pixel});
      tick();
      pix_valid = 1'b0;
      tick();
    end
    href = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_frame(input int nlines, input int ncols, input bit push);
    vsync();
    for (int l = 0; l < nlines; l++) send_line(ncols, l, push, l[0]);
  endtask

  task automatic pulse_cap0();
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    tick();
  endtask

  initial begin
    int base_wr, base_fd;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_wren", wren0, 0);
    chk("rst_wraddr", wraddr0, 0);
    chk("rst_wrdata", wrdata0, 0);
    chk("rst_banks", {wr_bank0, rd_bank0}, 2'b01);
    chk("rst_frame_done", frame_done0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_frame_count", frame_count0, 0);

    // One-shot: 4 lines x 130 pixels, stray capture mid-frame, second frame ignored
    pulse_cap0();
    chk("armed_busy", busy0, 1);
    vsync();
    send_line(130, 0, 1'b1, 1'b0);
    send_line(130, 1, 1'b1, 1'b1);
    pulse_cap0();
    send_line(130, 2, 1'b1, 1'b0);
    send_line(130, 3, 1'b1, 1'b1);
    chk("t1_writes", wr_cnt, 480);
    chk("t1_first_addr", first_addr, 15'h0000);
    chk("t1_last_addr", last_addr, 15'h01F7);
    send_frame(4, 130, 1'b0);
    vsync();
    chk("t1_frame_done", fd0_cnt, 1);
    chk("t1_writes_after", wr_cnt, 480);
    chk("t1_banks", {wr_bank0, rd_bank0}, 2'b10);
    chk("t1_frame_count", frame_count0, 1);
    chk("t1_idle", busy0, 0);

    // 125-line frame: rows beyond 119 dropped
    base_wr = wr_cnt;
    pulse_cap0();
    send_frame(125, 122, 1'b1);
    vsync();
    chk("t2_writes", wr_cnt - base_wr, 14400);
    chk("t2_seen_3b80", seen_3b80, 1);
    chk("t2_last_addr", last_addr, 15'h3BF7);
    chk("t2_frame_done", fd0_cnt, 2);
    chk("t2_banks", {wr_bank0, rd_bank0}, 2'b01);

    // Reader lock holds the swap
    pulse_cap0();
    send_frame(3, 10, 1'b1);
    rd_lock = 1'b1;
    vsync();
    send_line(10, 0, 1'b0, 1'b0);
    repeat (30) tick();
    chk("t3_hold_fd", fd0_cnt, 2);
    chk("t3_hold_banks", {wr_bank0, rd_bank0}, 2'b01);
    chk("t3_hold_busy", busy0, 1);
    rd_lock = 1'b0;
    tick();
    chk("t3_release_fd", frame_done0, 1);
    chk("t3_release_banks", {wr_bank0, rd_bank0}, 2'b10);
    tick();
    chk("t3_fd_pulse", frame_done0, 0);
    chk("t3_idle", busy0, 0);
    chk("t3_frame_count", frame_count0, 3);

    // Continuous instance: three frames, capture re-arms automatically
    cap1 = 1'b1;
    tick();
    cap1 = 1'b0;
    tick();
    mon_busy1 = 1'b1;
    chk("t4_bank_start", wr_bank1, 0);
    for (int k = 1; k <= 3; k++) begin
      send_frame(2, 4, 1'b0);
      vsync();
      chk($sformatf("t4_bank_%0d", k), wr_bank1, k % 2);
      send_line(4, 0, 1'b0, 1'b0);
      send_line(4, 1, 1'b0, 1'b1);
    end
    chk("t4_frame_done", fd1_cnt, 3);
    chk("t4_frame_count", frame_count1, 3);
    chk("t4_writes", wr1_cnt, 24);

    // Lock release coincident with vsync rise: swap happens, rise does not arm
    send_frame(2, 4, 1'b0);
    rd_lock = 1'b1;
    vref = 1'b1;
    repeat (6) tick();
    vref = 1'b0;
    repeat (4) tick();
    chk("t4_locked_fd", fd1_cnt, 3);
    vref = 1'b1;
    rd_lock = 1'b0;
    tick();
    chk("t4_coinc_fd", frame_done1, 1);
    repeat (4) tick();
    vref = 1'b0;
    repeat (3) tick();
    send_line(4, 0, 1'b0, 1'b0);
    send_line(4, 1, 1'b0, 1'b1);
    chk("t4_no_arm_writes", wr1_cnt, 32);
    chk("t4_coinc_count", fd1_cnt, 4);
    send_frame(2, 4, 1'b0);
    chk("t4_rearm_writes", wr1_cnt, 40);
    chk("t4_busy_drops", busy1_drop, 0);
    mon_busy1 = 1'b0;

    // Reset midway through line 10 abandons the frame
    pulse_cap0();
    vsync();
    for (int l = 0; l < 9; l++) send_line(20, l, 1'b1, l[0]);
    href = 1'b1;
    for (int c = 0; c < 5; c++) begin
      pixel = pix_of(9, c);
      pix_valid = 1'b1;
      exp_q.push_back({7'(9), 7'(c), pixel});
      tick();
      pix_valid = 1'b0;
      tick();
    end
    reset = 1'b1;
    tick();
    chk("t5_wren", wren0, 0);
    chk("t5_busy", busy0, 0);
    chk("t5_banks", {wr_bank0, rd_bank0}, 2'b01);
    chk("t5_frame_count", frame_count0, 0);
    chk("t5_frame_done", frame_done0, 0);
    reset = 1'b0;
    href = 1'b0;
    tick();
    base_fd = fd0_cnt;
    send_frame(2, 10, 1'b0);
    vsync();
    chk("t5_no_swap", fd0_cnt - base_fd, 0);
    chk("t5_still_idle", busy0, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
Sequences one-shot or continuous frame capture from the camera pixel stream into a ping-pong pair of 120x120 frame buffers. Tracks frame and line sync, generates windowed write addresses and strobes, and swaps the write and read banks at end of frame. Bank swapping is gated by a display-side read lock, so the reader never sees a half-written bank. Sits between the byte-to-pixel assembler and the two frame RAMs; all inputs are already synchronous to clk.

Parameters:
WIDTH, 120, captured columns per line (must be <=128)
HEIGHT, 120, captured lines per frame (must be <=128)
CONTINUOUS, 0, 1 = re-arm automatically after each swap; 0 = wait for next capture pulse

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
capture  input  1  single-cycle capture request
vref  input  1  vertical sync (high = blanking/sync)
href  input  1  line valid
pix_valid  input  1  one-cycle strobe: pixel holds a new assembled pixel
pixel  input  16  assembled pixel
rd_lock  input  1  reader is using rd_bank; swap forbidden while high
wren  output  1  write strobe to bank wr_bank
wraddr  output  15  {y[6:0], x[6:0]}
wrdata  output  16  pixel to write
wr_bank  output  1  bank being written
rd_bank  output  1  bank available to reader (always ~wr_bank)
frame_done  output  1  one-cycle pulse on bank swap
busy  output  1  high in every state except IDLE
frame_count  output  8  completed frames, wraps 255->0

Behaviour:
- Reset (sync, any state): state=IDLE, wren=0, wraddr=0, wrdata=0, wr_bank=0, rd_bank=1, frame_done=0, busy=0, frame_count=0, x=y=0. Reset mid-capture abandons the frame; no swap occurs.
- Edge detection: registered vref_d and href_d; rise = sig & ~sig_d.
- IDLE: capture=1 -> ARM. capture is ignored in every other state.
- ARM: wait for vref rise -> SYNC. Arming mid-frame discards the partial frame.
- SYNC: vref low -> CAPTURE; x=0, y=0, first_line=1.
- CAPTURE:
  - href rise: x=0; y stays 0 if first_line (then clear first_line), otherwise y=y+1, saturating at 1023.
  - pix_valid & href: if x<WIDTH and y<HEIGHT, then next cycle wren=1, wraddr={y[6:0],x[6:0]}, wrdata=pixel (latency 1 cycle). x=x+1 saturating at 1023; out-of-window pixels are dropped with wren=0.
  - href rise and pix_valid in the same cycle: the pixel is written at x=0 of the new line, and x becomes 1.
  - vref rise -> SWAP. wren is never asserted outside CAPTURE.
- SWAP:
  - rd_lock=0: toggle wr_bank and rd_bank, pulse frame_done for 1 cycle, increment frame_count. Then go to ARM if CONTINUOUS=1, else IDLE.
  - rd_lock=1: hold in SWAP with no writes. Frames arriving during the hold are lost.
  - rd_lock falling and vref rise in the same cycle: swap first, and that vref rise is not used to arm.
- x and y are 10-bit; only bits [6:0] form the address. The x<WIDTH and y<HEIGHT window check guarantees no aliasing.

Test Plan:
- Reset, capture pulse, 2 frames of 4 lines x 130 pixels (CONTINUOUS=0) -> exactly 4x120=480 wren pulses. First wraddr=0x0000; last of line 3 = {7'd3,7'd119}=0x01F7. One frame_done; wr_bank 0->1; frame_count=1; state IDLE; second frame ignored.
- Frame of 125 lines -> no wren for y>=120; the 120th line writes wraddr top row 119 (0x3B80..0x3BF7).
- rd_lock held high at frame end for 50 cycles -> stays in SWAP, no frame_done, banks unchanged. Lock drops -> frame_done next cycle, banks swap.
- CONTINUOUS=1, 3 frames -> 3 frame_done pulses; wr_bank 0,1,0,1; frame_count=3; busy never drops.
- Reset asserted midway through line 10 -> next cycle wren=0, busy=0, wr_bank=0, frame_count=0, no frame_done.
- capture pulse while in CAPTURE -> ignored; href rise coincident with pix_valid -> write at x=0 of the new line, and the next pixel is written at x=1.
